// File: rtl/key_conditioner.sv
// -----------------------------------------------------------------------------
// key_conditioner
//
// Front-end conditioning for four raw active-low push-buttons. Each key is
// synchronised through two flops and then debounced. The debounced levels
// drive these outputs:
//   - inc / inc2 : one-cycle pulses with hold-to-repeat, from keys 0 and 1
//   - sel        : a toggled select level, from key 2
//   - clr        : a one-cycle clear pulse, from key 3
// All outputs are in the clk domain and are registered.
//
// Ports:
//   clk      in   1  system clock, rising edge
//   res      in   1  synchronous active-low reset
//   key_n    in   4  raw asynchronous buttons, 0 = pressed
//                    [0] inc, [1] inc2, [2] select, [3] clear
//   inc      out  1  pulse per accepted press or repeat of key 0
//   inc2     out  1  pulse per accepted press or repeat of key 1
//   sel      out  1  level, toggles on each accepted press of key 2
//   clr      out  1  pulse per accepted press of key 3
//   pressed  out  4  debounced key state, 1 = pressed
// -----------------------------------------------------------------------------
module key_conditioner #(
  parameter int DB_CYCLES     = 1000000,
  parameter int HOLD_CYCLES   = 25000000,
  parameter int REPEAT_CYCLES = 5000000
) (
  input  logic       clk,
  input  logic       res,
  input  logic [3:0] key_n,
  output logic       inc,
  output logic       inc2,
  output logic       sel,
  output logic       clr,
  output logic [3:0] pressed
);

  localparam int DB_W    = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
  localparam int RPT_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int RPT_W   = (RPT_MAX > 2) ? $clog2(RPT_MAX) : 1;

  localparam logic [DB_W-1:0]  DB_LAST   = DB_W'(DB_CYCLES - 1);
  localparam logic [DB_W-1:0]  DB_ZERO   = DB_W'(0);
  localparam logic [DB_W-1:0]  DB_ONE    = DB_W'(1);
  localparam logic [RPT_W-1:0] HOLD_LAST = RPT_W'(HOLD_CYCLES - 1);
  localparam logic [RPT_W-1:0] RPT_LAST  = RPT_W'(REPEAT_CYCLES - 1);
  localparam logic [RPT_W-1:0] RPT_ZERO  = RPT_W'(0);
  localparam logic [RPT_W-1:0] RPT_ONE   = RPT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_REPEAT = 2'd2
  } rpt_state_t;

  logic [3:0] sync1_r;
  logic [3:0] sync2_r;
  logic [3:0] sync_s;
  logic [3:0] pressed_s;
  logic [3:0] pressed_q_r;
  logic [3:0] rise_s;
  logic [1:0] fall_s;
  logic [1:0] rpt_pulse_s;

  // Two-stage synchroniser; resets to the released level (1).
  always_ff @(posedge clk) begin
    if (!res) begin
      sync1_r <= 4'hF;
      sync2_r <= 4'hF;
    end else begin
      sync1_r <= key_n;
      sync2_r <= sync1_r;
    end
  end

  // Convert the synchronised active-low keys to active-high "pressed" sense.
  assign sync_s = ~sync2_r;

  for (genvar k = 0; k < 4; k++) begin : g_db
    logic [DB_W-1:0] db_cnt_r;
    logic            db_level_r;

    // Debounce: count consecutive cycles of disagreement with the accepted
    // level. Any agreement (a bounce) restarts the count. On the last count
    // the accepted level flips.
    always_ff @(posedge clk) begin
      if (!res) begin
        db_cnt_r   <= DB_ZERO;
        db_level_r <= 1'b0;
      end else if (sync_s[k] == db_level_r) begin
        db_cnt_r   <= DB_ZERO;
        db_level_r <= db_level_r;
      end else if (db_cnt_r >= DB_LAST) begin
        db_cnt_r   <= DB_ZERO;
        db_level_r <= ~db_level_r;
      end else begin
        db_cnt_r   <= db_cnt_r + DB_ONE;
        db_level_r <= db_level_r;
      end
    end

    assign pressed_s[k] = db_level_r;
  end

  // Delayed copy of the debounced levels for press/release edge detection.
  always_ff @(posedge clk) begin
    if (!res) begin
      pressed_q_r <= 4'h0;
    end else begin
      pressed_q_r <= pressed_s;
    end
  end

  assign rise_s = pressed_s & ~pressed_q_r;
  assign fall_s = ~pressed_s[1:0] & pressed_q_r[1:0];

  for (genvar k = 0; k < 2; k++) begin : g_rpt
    rpt_state_t       state_r;
    rpt_state_t       state_nx_s;
    logic [RPT_W-1:0] cnt_r;
    logic [RPT_W-1:0] cnt_nx_s;
    logic             pulse_s;

    // Repeat FSM state and counter registers.
    always_ff @(posedge clk) begin
      if (!res) begin
        state_r <= ST_IDLE;
        cnt_r   <= RPT_ZERO;
      end else begin
        state_r <= state_nx_s;
        cnt_r   <= cnt_nx_s;
      end
    end

    // Repeat FSM next state. A release wins over a due repeat pulse, so
    // letting go never produces a trailing pulse.
    always_comb begin
      state_nx_s = state_r;
      cnt_nx_s   = cnt_r;
      pulse_s    = 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (rise_s[k]) begin
            pulse_s    = 1'b1;
            cnt_nx_s   = RPT_ZERO;
            state_nx_s = ST_HOLD;
          end else begin
            cnt_nx_s   = RPT_ZERO;
          end
        end
        ST_HOLD: begin
          if (fall_s[k]) begin
            cnt_nx_s   = RPT_ZERO;
            state_nx_s = ST_IDLE;
          end else if (cnt_r >= HOLD_LAST) begin
            pulse_s    = 1'b1;
            cnt_nx_s   = RPT_ZERO;
            state_nx_s = ST_REPEAT;
          end else begin
            cnt_nx_s   = cnt_r + RPT_ONE;
          end
        end
        ST_REPEAT: begin
          if (fall_s[k]) begin
            cnt_nx_s   = RPT_ZERO;
            state_nx_s = ST_IDLE;
          end else if (cnt_r >= RPT_LAST) begin
            pulse_s    = 1'b1;
            cnt_nx_s   = RPT_ZERO;
          end else begin
            cnt_nx_s   = cnt_r + RPT_ONE;
          end
        end
        default: begin
          cnt_nx_s   = RPT_ZERO;
          state_nx_s = ST_IDLE;
        end
      endcase
    end

    assign rpt_pulse_s[k] = pulse_s;
  end

  // Output registers. A held clear key masks the increment pulses. The
  // repeat FSMs keep running underneath, so masked pulses are dropped.
  always_ff @(posedge clk) begin
    if (!res) begin
      inc  <= 1'b0;
      inc2 <= 1'b0;
      clr  <= 1'b0;
      sel  <= 1'b0;
    end else begin
      inc  <= rpt_pulse_s[0] & ~pressed_s[3];
      inc2 <= rpt_pulse_s[1] & ~pressed_s[3];
      clr  <= rise_s[3];
      sel  <= sel ^ rise_s[2];
    end
  end

  assign pressed = pressed_s;

endmodule

// File: tb/tb_key_conditioner.sv
// -----------------------------------------------------------------------------
// tb_key_conditioner
//
// Self-checking bench for key_conditioner with small timing parameters.
//
// The reference model works from sampled-key history and press timestamps:
//   - A key's debounced level flips at edge t when the raw samples taken at
//     edges t-5 .. t-2 all disagree with the current level.
//   - A press is reported one edge later, at edge t0.
//   - A repeat key pulses at elapsed times d = 0, HOLD, HOLD + n*REPEAT while
//     the key remains accepted.
// -----------------------------------------------------------------------------
module tb_key_conditioner;

  localparam int DB   = 4;
  localparam int HOLD = 10;
  localparam int RPT  = 3;
  localparam int MAXC = 8192;

  logic       clk = 1'b0;
  logic       res;
  logic [3:0] key_n;
  logic       inc;
  logic       inc2;
  logic       sel;
  logic       clr;
  logic [3:0] pressed;

  key_conditioner #(
    .DB_CYCLES    (DB),
    .HOLD_CYCLES  (HOLD),
    .REPEAT_CYCLES(RPT)
  ) dut (
    .clk    (clk),
    .res    (res),
    .key_n  (key_n),
    .inc    (inc),
    .inc2   (inc2),
    .sel    (sel),
    .clr    (clr),
    .pressed(pressed)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state.
  logic [3:0] smp [MAXC];
  int         ecnt = 0;
  logic [3:0] m_pressed;
  logic       m_inc;
  logic       m_inc2;
  logic       m_sel;
  logic       m_clr;
  int         t0  [4];
  bit         act [2];

  int cnt_inc;
  int cnt_inc2;
  int cnt_clr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  function automatic bit rpt_due(input int d);
    return (d == 0) || (d == HOLD) || (d > HOLD && ((d - HOLD) % RPT) == 0);
  endfunction

  task automatic model_edge(input logic [3:0] kn, input logic rs);
    int t;
    bit p0;
    bit p1;
    bit flip;
    t = ecnt;
    if (t >= MAXC) begin
      $display("FAIL model_depth: edge %0d exceeds history %0d", t, MAXC);
      $fatal(1);
    end
    if (!rs) begin
      // Reset wipes both synchroniser stages back to the released level.
      smp[t] = 4'h0;
      if (t > 0) smp[t-1] = 4'h0;
      m_pressed = 4'h0;
      m_inc  = 1'b0;
      m_inc2 = 1'b0;
      m_clr  = 1'b0;
      m_sel  = 1'b0;
      for (int k = 0; k < 4; k++) t0[k] = -1;
      act[0] = 1'b0;
      act[1] = 1'b0;
    end else begin
      smp[t] = ~kn;
      p0 = act[0] && rpt_due(t - t0[0]);
      p1 = act[1] && rpt_due(t - t0[1]);
      m_inc  = p0 && !m_pressed[3];
      m_inc2 = p1 && !m_pressed[3];
      m_clr  = (t0[3] == t);
      if (t0[2] == t) m_sel = ~m_sel;
      for (int k = 0; k < 4; k++) begin
        flip = (t >= DB + 1);
        for (int j = 2; j <= DB + 1; j++) begin
          if (t >= j && smp[t-j][k] == m_pressed[k]) flip = 1'b0;
        end
        if (flip) begin
          m_pressed[k] = ~m_pressed[k];
          if (m_pressed[k]) t0[k] = t + 1;
          if (k < 2) act[k] = m_pressed[k];
        end
      end
    end
    ecnt++;
  endtask

  task automatic step(input logic [3:0] kn, input logic rs);
    key_n = kn;
    res   = rs;
    @(posedge clk);
    model_edge(kn, rs);
    @(negedge clk);
    check("inc",     {31'd0, inc},     {31'd0, m_inc});
    check("inc2",    {31'd0, inc2},    {31'd0, m_inc2});
    check("sel",     {31'd0, sel},     {31'd0, m_sel});
    check("clr",     {31'd0, clr},     {31'd0, m_clr});
    check("pressed", {28'd0, pressed}, {28'd0, m_pressed});
    cnt_inc  += int'(inc);
    cnt_inc2 += int'(inc2);
    cnt_clr  += int'(clr);
  endtask

  task automatic run(input logic [3:0] kn, input int n);
    for (int i = 0; i < n; i++) step(kn, 1'b1);
  endtask

  task automatic clear_counts();
    cnt_inc  = 0;
    cnt_inc2 = 0;
    cnt_clr  = 0;
  endtask

  logic [3:0] kn_cur;
  int         hold_left [4];

  initial begin
    key_n = 4'hF;
    res   = 1'b0;
    clear_counts();

    // Reset, then all keys released for 20 cycles.
    for (int i = 0; i < 3; i++) step(4'hF, 1'b0);
    run(4'hF, 20);
    check("idle_pressed", {28'd0, pressed}, 32'd0);

    // Single press of key 0 for 8 cycles: exactly one inc pulse.
    clear_counts();
    run(4'hE, 8);
    run(4'hF, 15);
    check("single_inc",  cnt_inc,  32'd1);
    check("single_inc2", cnt_inc2, 32'd0);
    check("single_clr",  cnt_clr,  32'd0);

    // Key 1 bouncing with 2-cycle phases is never accepted.
    clear_counts();
    for (int i = 0; i < 20; i++) step((((i / 2) % 2) == 0) ? 4'hD : 4'hF, 1'b1);
    run(4'hF, 4);
    check("bounce_inc2", cnt_inc2, 32'd0);
    run(4'hD, 8);
    run(4'hF, 15);
    check("settle_inc2", cnt_inc2, 32'd1);

    // Key 0 held 40 cycles: pulses at d = 0, 10, 13, ..., 37.
    clear_counts();
    run(4'hE, 40);
    run(4'hF, 20);
    check("repeat_inc", cnt_inc, 32'd11);

    // Three separated presses of key 2 toggle sel; a reset clears it.
    for (int p = 0; p < 3; p++) begin
      run(4'hB, 8);
      run(4'hF, 12);
    end
    check("sel_three", {31'd0, sel}, 32'd1);
    step(4'hF, 1'b0);
    check("sel_reset", {31'd0, sel}, 32'd0);
    run(4'hF, 5);

    // Clear key held while key 0 is pressed and released: inc is masked.
    clear_counts();
    run(4'h7, 4);
    run(4'h6, 15);
    run(4'h7, 10);
    run(4'hF, 20);
    check("mask_inc", cnt_inc, 32'd0);
    check("mask_clr", cnt_clr, 32'd1);

    // Reset while key 0 is auto-repeating.
    run(4'hE, 25);
    step(4'hE, 1'b0);
    check("rst_rpt_inc",     {31'd0, inc},     32'd0);
    check("rst_rpt_pressed", {28'd0, pressed}, 32'd0);
    run(4'hE, 10);
    run(4'hF, 20);

    // Random key activity with occasional resets.
    kn_cur = 4'hF;
    for (int k = 0; k < 4; k++) hold_left[k] = $urandom_range(0, 20);
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < 4; k++) begin
        if (hold_left[k] == 0) begin
          kn_cur[k] = ~kn_cur[k];
          if ($urandom_range(0, 3) == 0) hold_left[k] = $urandom_range(1, 3);
          else                           hold_left[k] = $urandom_range(3, 30);
          if (k == 3 && kn_cur[3]) hold_left[k] = hold_left[k] + 40;
        end else begin
          hold_left[k] = hold_left[k] - 1;
        end
      end
      step(kn_cur, ($urandom_range(0, 299) != 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
